// File: rtl/mem_dma.sv
`default_nettype none
// ============================================================================
//  Module      : mem_dma
//  Description : Bus-master block copy / fill engine for a synchronous
//                64 KiB memory with a registered read port. Requests the
//                memory port from the arbiter and moves one byte per
//                READ-LATCH-WRITE sequence (copy) or per WRITE cycle (fill).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_dma #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Start,
    input  logic              Mode,
    input  logic [ADDR_W-1:0] SrcAddr,
    input  logic [ADDR_W-1:0] DstAddr,
    input  logic [LEN_W-1:0]  Length,
    input  logic [7:0]        FillValue,
    output logic              BusReq,
    input  logic              BusGrant,
    output logic              MemWE,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [7:0]        MemDataIn,
    input  logic [7:0]        MemDataOut,
    output logic              Busy,
    output logic              Done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LATCH = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  rem_q;
    logic [7:0]        fill_q;
    logic              mode_q;
    logic [7:0]        buf_q;
    logic              busreq_q;
    logic              busy_q;
    logic              done_q;

    // Bus values: driven in READ/WRITE, otherwise the last driven value is held
    logic [ADDR_W-1:0] mem_addr_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_din_d;
    logic [7:0]        mem_din_q;

    // Transfer sequencer: operand latching, address/count stepping, status flags
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            rem_q    <= '0;
            fill_q   <= '0;
            mode_q   <= 1'b0;
            buf_q    <= '0;
            busreq_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        src_q  <= SrcAddr;
                        dst_q  <= DstAddr;
                        rem_q  <= Length;
                        fill_q <= FillValue;
                        mode_q <= Mode;
                        if (Length == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= Mode ? S_WRITE : S_READ;
                            busreq_q <= 1'b1;
                            busy_q   <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (BusGrant) begin
                        state_q <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    // Read data is captured regardless of grant
                    buf_q   <= MemDataOut;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    if (BusGrant) begin
                        dst_q <= dst_q + ADDR_W'(1);
                        rem_q <= rem_q - LEN_W'(1);
                        if (!mode_q) begin
                            src_q <= src_q + ADDR_W'(1);
                        end
                        if (rem_q == LEN_W'(1)) begin
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                            busreq_q <= 1'b0;
                            busy_q   <= 1'b0;
                        end else if (!mode_q) begin
                            state_q <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Select the address/data placed on the bus this cycle
    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        if (state_q == S_READ) begin
            mem_addr_d = src_q;
        end else if (state_q == S_WRITE) begin
            mem_addr_d = dst_q;
            mem_din_d  = mode_q ? fill_q : buf_q;
        end
    end

    // Remember the last driven bus values so they hold between accesses
    always_ff @(posedge CLK) begin
        if (RST) begin
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
        end
    end

    assign MemAddress = mem_addr_d;
    assign MemDataIn  = mem_din_d;
    // Write strobe only when granted, and never while reset is asserted
    assign MemWE      = (state_q == S_WRITE) & BusGrant & ~RST;
    assign BusReq     = busreq_q;
    assign Busy       = busy_q;
    assign Done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_dma.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_dma
//  Description : Self-checking bench for mem_dma with a behavioural memory
//                and a byte-sequential reference model of copy/fill.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_dma;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Start;
    logic        Mode;
    logic [15:0] SrcAddr;
    logic [15:0] DstAddr;
    logic [15:0] Length;
    logic [7:0]  FillValue;
    logic        BusReq;
    logic        BusGrant;
    logic        MemWE;
    logic [15:0] MemAddress;
    logic [7:0]  MemDataIn;
    logic [7:0]  MemDataOut;
    logic        Busy;
    logic        Done;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic        bd_init;
    logic        bd_we;
    logic [15:0] bd_addr;
    logic [7:0]  bd_data;

    logic [15:0] wr_a [$];
    logic [7:0]  wr_d [$];

    mem_dma #(.ADDR_W(16), .LEN_W(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Start      (Start),
        .Mode       (Mode),
        .SrcAddr    (SrcAddr),
        .DstAddr    (DstAddr),
        .Length     (Length),
        .FillValue  (FillValue),
        .BusReq     (BusReq),
        .BusGrant   (BusGrant),
        .MemWE      (MemWE),
        .MemAddress (MemAddress),
        .MemDataIn  (MemDataIn),
        .MemDataOut (MemDataOut),
        .Busy       (Busy),
        .Done       (Done)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] init_val(input int i);
        return 8'((i * 37) ^ (i >> 8) ^ 90);
    endfunction

    // Synchronous memory with registered read data and a backdoor
    always @(posedge CLK) begin
        if (bd_init) begin
            for (int i = 0; i < 65536; i++) mem[i] <= init_val(i);
        end else begin
            if (bd_we) mem[bd_addr] <= bd_data;
            else if (MemWE) mem[MemAddress] <= MemDataIn;
        end
        MemDataOut <= mem[MemAddress];
    end

    // Log of every write the engine performs
    always @(posedge CLK) begin
        if (MemWE) begin
            wr_a.push_back(MemAddress);
            wr_d.push_back(MemDataIn);
        end
    end

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        @(negedge CLK);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(negedge CLK);
        bd_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic mem_compare(input string name);
        int bad;
        int first;
        bad = 0; first = -1;
        for (int i = 0; i < 65536; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                if (first < 0) first = i;
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d bytes differ, first at %h got %h required %h",
                     name, bad, first[15:0], mem[first], ref_mem[first]);
        end
    endtask

    // Issue one command, follow it to Done and check everything against the model
    task automatic run_op(input string name, input logic mode, input logic [15:0] src,
                          input logic [15:0] dst, input logic [15:0] len,
                          input logic [7:0] fill, input int gmode, input bit inject,
                          input int exp_lat);
        logic [15:0] exp_a [$];
        logic [7:0]  exp_d [$];
        logic [15:0] a;
        logic [7:0]  v;
        int n;
        int bound;
        bit breq_seen;
        bit got_done;
        int bad;

        for (int i = 0; i < int'(len); i++) begin
            a = dst + 16'(i);
            v = mode ? fill : ref_mem[src + 16'(i)];
            ref_mem[a] = v;
            exp_a.push_back(a);
            exp_d.push_back(v);
        end
        bound = 200 + 40 * int'(len);

        @(negedge CLK);
        wr_a.delete(); wr_d.delete();
        Mode = mode; SrcAddr = src; DstAddr = dst; Length = len; FillValue = fill;
        BusGrant = 1'b1; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        Mode = ~mode; SrcAddr = 16'h1234; DstAddr = 16'h4321; Length = 16'd0;
        n = 1; breq_seen = 1'b0; got_done = 1'b0;
        while (n <= bound) begin
            case (gmode)
                1:       BusGrant = ($urandom_range(0, 9) < 7);
                2:       BusGrant = !(n == 1 || n == 2 || n == 3 || n == 6 || n == 7);
                default: BusGrant = 1'b1;
            endcase
            if (inject && n == 2) begin
                Start = 1'b1; Mode = 1'b1; Length = 16'd0; FillValue = 8'h77;
            end else begin
                Start = 1'b0;
            end
            #1;
            if (BusReq) breq_seen = 1'b1;
            if (gmode == 2 && !BusGrant) begin
                checks++;
                if (MemWE !== 1'b0) begin
                    errors++;
                    $display("FAIL %s stall_we: cycle %0d MemWE=%b required 0", name, n, MemWE);
                end
            end
            if (n == 1 && len != 0) begin
                checks++;
                if (Busy !== 1'b1 || BusReq !== 1'b1) begin
                    errors++;
                    $display("FAIL %s active_flags: Busy=%b BusReq=%b required 1 1", name, Busy, BusReq);
                end
            end
            if (Done === 1'b1) begin
                got_done = 1'b1;
                break;
            end
            @(negedge CLK);
            n++;
        end
        Start = 1'b0;
        BusGrant = 1'b1;

        checks++;
        if (!got_done) begin
            errors++;
            $display("FAIL %s done_timeout: no Done within %0d cycles", name, bound);
        end
        if (exp_lat >= 0) begin
            checks++;
            if (n != exp_lat) begin
                errors++;
                $display("FAIL %s latency: got %0d cycles required %0d", name, n, exp_lat);
            end
        end
        checks++;
        if (Busy !== 1'b0 || BusReq !== 1'b0) begin
            errors++;
            $display("FAIL %s done_flags: Busy=%b BusReq=%b required 0 0", name, Busy, BusReq);
        end
        if (len == 0) begin
            checks++;
            if (breq_seen) begin
                errors++;
                $display("FAIL %s zero_busreq: BusReq seen=1 required 0", name);
            end
        end
        @(negedge CLK);
        #1;
        checks++;
        if (Done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: Done=%b one cycle later required 0", name, Done);
        end

        checks++;
        if (wr_a.size() != exp_a.size()) begin
            errors++;
            $display("FAIL %s write_count: got %0d required %0d", name, wr_a.size(), exp_a.size());
        end else begin
            bad = -1;
            for (int i = 0; i < exp_a.size(); i++)
                if (bad < 0 && (wr_a[i] !== exp_a[i] || wr_d[i] !== exp_d[i])) bad = i;
            if (bad >= 0) begin
                errors++;
                $display("FAIL %s write_seq: write %0d got %h<=%h required %h<=%h",
                         name, bad, wr_a[bad], wr_d[bad], exp_a[bad], exp_d[bad]);
            end
        end
        mem_compare(name);
    endtask

    task automatic test_reset();
        RST = 1'b1; Start = 1'b1; Mode = 1'b1; BusGrant = 1'b1;
        SrcAddr = 16'hAAAA; DstAddr = 16'h5555; Length = 16'd5; FillValue = 8'hFF;
        bd_init = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        repeat (3) @(negedge CLK);
        #1;
        checks++;
        if ({BusReq, Busy, Done, MemWE} !== 4'b0000 || MemAddress !== 16'h0 || MemDataIn !== 8'h0) begin
            errors++;
            $display("FAIL reset_values: BusReq=%b Busy=%b Done=%b MemWE=%b Addr=%h Din=%h required all 0",
                     BusReq, Busy, Done, MemWE, MemAddress, MemDataIn);
        end
        Start = 1'b0;
        bd_init = 1'b1;
        @(negedge CLK);
        bd_init = 1'b0;
        RST = 1'b0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);
        @(negedge CLK);
    endtask

    task automatic test_copy_basic();
        poke(16'h0037, 8'hDD);
        poke(16'h0038, 8'hEE);
        run_op("copy_basic", 1'b0, 16'h0037, 16'h0200, 16'd2, 8'h00, 0, 1'b0, 7);
        checks++;
        if (mem[16'h0200] !== 8'hDD || mem[16'h0201] !== 8'hEE) begin
            errors++;
            $display("FAIL copy_basic_bytes: got %h %h required dd ee", mem[16'h0200], mem[16'h0201]);
        end
    endtask

    task automatic test_fill_wrap();
        run_op("fill_wrap", 1'b1, 16'h0000, 16'hFFFE, 16'd4, 8'hA5, 0, 1'b0, 5);
        checks++;
        if (wr_a.size() != 4 || wr_a[0] !== 16'hFFFE || wr_a[1] !== 16'hFFFF ||
            wr_a[2] !== 16'h0000 || wr_a[3] !== 16'h0001) begin
            errors++;
            $display("FAIL fill_wrap_addrs: got %0d writes required fffe ffff 0000 0001", wr_a.size());
        end
    endtask

    task automatic test_grant_stall();
        poke(16'h0110, 8'hBB);
        run_op("grant_stall", 1'b0, 16'h0110, 16'h0300, 16'd1, 8'h00, 2, 1'b0, 9);
        checks++;
        if (mem[16'h0300] !== 8'hBB) begin
            errors++;
            $display("FAIL grant_stall_byte: got %h required bb", mem[16'h0300]);
        end
    endtask

    task automatic test_zero_len();
        run_op("zero_len", 1'b0, 16'h0100, 16'h0900, 16'd0, 8'h00, 0, 1'b0, 1);
    endtask

    task automatic test_ignored_start();
        run_op("ignored_start", 1'b0, 16'h0400, 16'h0500, 16'd3, 8'h00, 0, 1'b1, 10);
    endtask

    task automatic test_reset_mid_copy();
        int n;
        logic [7:0] first;
        bit done_seen;
        first = ref_mem[16'h0600];
        @(negedge CLK);
        wr_a.delete(); wr_d.delete();
        Mode = 1'b0; SrcAddr = 16'h0600; DstAddr = 16'h0700; Length = 16'd4;
        BusGrant = 1'b1; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        n = 1;
        while (n < 6) begin
            @(negedge CLK);
            n++;
        end
        RST = 1'b1;
        #1;
        checks++;
        if (MemWE !== 1'b0) begin
            errors++;
            $display("FAIL rst_we_forced: MemWE=%b during reset required 0", MemWE);
        end
        @(negedge CLK);
        #1;
        checks++;
        if ({BusReq, Busy, Done, MemWE} !== 4'b0000 || MemAddress !== 16'h0 || MemDataIn !== 8'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs: BusReq=%b Busy=%b Done=%b MemWE=%b Addr=%h Din=%h required all 0",
                     BusReq, Busy, Done, MemWE, MemAddress, MemDataIn);
        end
        RST = 1'b0;
        done_seen = 1'b0;
        repeat (12) begin
            @(negedge CLK);
            #1;
            if (Done) done_seen = 1'b1;
        end
        checks++;
        if (done_seen) begin
            errors++;
            $display("FAIL rst_mid_done: Done pulse seen=1 required 0");
        end
        checks++;
        if (wr_a.size() != 1 || wr_a[0] !== 16'h0700 || wr_d[0] !== first) begin
            errors++;
            $display("FAIL rst_mid_writes: got %0d writes required 1 write of %h to 0700", wr_a.size(), first);
        end
        ref_mem[16'h0700] = first;
        mem_compare("rst_mid_mem");
    endtask

    task automatic test_overlap();
        poke(16'h0010, 8'h01);
        poke(16'h0011, 8'h02);
        poke(16'h0012, 8'h03);
        run_op("overlap", 1'b0, 16'h0010, 16'h0011, 16'd2, 8'h00, 0, 1'b0, 7);
        checks++;
        if (mem[16'h0011] !== 8'h01 || mem[16'h0012] !== 8'h01) begin
            errors++;
            $display("FAIL overlap_bytes: got %h %h required 01 01", mem[16'h0011], mem[16'h0012]);
        end
    endtask

    task automatic test_random();
        logic        m;
        logic [15:0] s;
        logic [15:0] d;
        logic [15:0] l;
        logic [7:0]  f;
        int          g;
        int          lat;
        for (int k = 0; k < 25; k++) begin
            m = 1'($urandom_range(0, 1));
            s = 16'($urandom);
            d = ($urandom_range(0, 3) == 0) ? s + 16'($urandom_range(0, 4)) : 16'($urandom);
            l = 16'($urandom_range(0, 20));
            f = 8'($urandom);
            g = $urandom_range(0, 1);
            if (g != 0) lat = -1;
            else if (l == 0) lat = 1;
            else lat = m ? int'(l) + 1 : 3 * int'(l) + 1;
            run_op($sformatf("random_%0d", k), m, s, d, l, f, g, 1'b0, lat);
        end
    endtask

    initial begin
        test_reset();
        test_copy_basic();
        test_fill_wrap();
        test_grant_stall();
        test_zero_len();
        test_ignored_start();
        test_reset_mid_copy();
        test_overlap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
